stat_display_ctrl: RTL and testbench

//  Board-level display sequencer for the single-cycle CPU FPGA build. Debounces the 3-bit mode switches,

---
 rtl/stat_display_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_stat_display_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_display_ctrl.sv
// stat_display_ctrl
//   Board-level display sequencer for the single-cycle CPU FPGA build.
//   Debounces the mode switches, picks one CPU statistic (or the data
//   memory word at the switch address), snapshots it once per scan frame
//   and time-multiplexes it as 8 hex digits onto the 7-segment display.
//
// Ports
//   clk               system clock, all logic on the rising edge
//   rst_n             asynchronous active-low reset
//   disp_en_i         master display switch, 0 blanks the display
//   mode_sw_i         raw (asynchronous, bouncy) mode switches
//   addr_sw_i         memory word address switches
//   pc_i              current PC
//   cycle_cnt_i       total cycle counter
//   br_cond_cnt_i     conditional branch count
//   br_taken_cnt_i    conditional branches taken
//   br_uncond_cnt_i   unconditional branch/jump count
//   mem_rdata_i       data memory word at mem_addr_o (combinational read)
//   mem_addr_o        registered address to the data memory read port
//   mode_q_o          accepted (debounced) mode, for LED echo
//   an_o              digit anodes, active-low, bit 0 = rightmost digit
//   seg_o             segments, active-low, {dp,g,f,e,d,c,b,a}
module stat_display_ctrl #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_en_i,
    input  logic [2:0]  mode_sw_i,
    input  logic [11:0] addr_sw_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] cycle_cnt_i,
    input  logic [31:0] br_cond_cnt_i,
    input  logic [31:0] br_taken_cnt_i,
    input  logic [31:0] br_uncond_cnt_i,
    input  logic [31:0] mem_rdata_i,
    output logic [11:0] mem_addr_o,
    output logic [2:0]  mode_q_o,
    output logic [7:0]  an_o,
    output logic [7:0]  seg_o
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
    localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);

    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    cand_q, cand_d;
    logic [DW-1:0] dbCnt_q, dbCnt_d;
    logic [2:0]    mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    digit_q, digit_d;
    logic [31:0]   snap_q, snap_d;
    logic [2:0]    snapMode_q, snapMode_d;
    logic [11:0]   memAddr_q, memAddr_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          scanWrap;
    logic          frameEnd;
    logic          blank;
    logic [31:0]   selWord;
    logic [3:0]    nibble;

    // Active-low 7-segment patterns {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] hexFont(input logic [3:0] v);
        logic [6:0] f;
        f = 7'b1111111;
        case (v)
            4'h0: f = 7'b1000000;
            4'h1: f = 7'b1111001;
            4'h2: f = 7'b0100100;
            4'h3: f = 7'b0110000;
            4'h4: f = 7'b0011001;
            4'h5: f = 7'b0010010;
            4'h6: f = 7'b0000010;
            4'h7: f = 7'b1111000;
            4'h8: f = 7'b0000000;
            4'h9: f = 7'b0010000;
            4'hA: f = 7'b0001000;
            4'hB: f = 7'b0000011;
            4'hC: f = 7'b1000110;
            4'hD: f = 7'b0100001;
            4'hE: f = 7'b0000110;
            4'hF: f = 7'b0001110;
        endcase
        return f;
    endfunction

    // Next-state logic for debounce, scan counters, frame snapshot and
    // the registered display outputs.
    always_comb begin
        cand_d     = cand_q;
        dbCnt_d    = dbCnt_q;
        mode_d     = mode_q;
        snap_d     = snap_q;
        snapMode_d = snapMode_q;
        memAddr_d  = memAddr_q;

        // Any change of the synchronized value restarts the hold count;
        // the count then parks at its last value while the mode is held.
        if (sync2_q != cand_q) begin
            cand_d  = sync2_q;
            dbCnt_d = '0;
        end else if (dbCnt_q == DB_LAST) begin
            mode_d = cand_q;
        end else begin
            dbCnt_d = dbCnt_q + DW'(1);
        end

        scanWrap = (presc_q == SCAN_LAST);
        frameEnd = scanWrap && (digit_q == 3'd7);
        presc_d  = scanWrap ? '0 : presc_q + PW'(1);
        digit_d  = scanWrap ? digit_q + 3'd1 : digit_q;

        case (mode_q)
            3'd0:    selWord = mem_rdata_i;
            3'd1:    selWord = pc_i;
            3'd2:    selWord = cycle_cnt_i;
            3'd3:    selWord = br_cond_cnt_i;
            3'd4:    selWord = br_taken_cnt_i;
            3'd5:    selWord = br_uncond_cnt_i;
            default: selWord = 32'd0;
        endcase

        // The snapshot only moves on the last cycle of digit 7 so every
        // digit of one frame comes from the same value. mem_rdata_i here
        // still belongs to the previous address, so a new address shows
        // one frame later.
        if (frameEnd) begin
            snap_d     = selWord;
            snapMode_d = mode_q;
            memAddr_d  = addr_sw_i;
        end

        // Blank modes blank both as soon as they are accepted and while a
        // snapshot taken in a blank mode is still the one on display.
        blank  = !disp_en_i || (mode_q[2:1] == 2'b11) || (snapMode_q[2:1] == 2'b11);
        nibble = snap_q[{digit_q, 2'b00} +: 4];

        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (!blank) begin
            an_d  = ~(8'b1 << digit_q);
            // The dot on digit 0 flags an accepted mode that has not yet
            // reached the display.
            seg_d = {~((digit_q == 3'd0) && (mode_q != snapMode_q)), hexFont(nibble)};
        end
    end

    // State registers; reset returns to a blank display with the scan at
    // digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            dbCnt_q    <= '0;
            mode_q     <= '0;
            presc_q    <= '0;
            digit_q    <= '0;
            snap_q     <= '0;
            snapMode_q <= '0;
            memAddr_q  <= '0;
            an_q       <= 8'hFF;
            seg_q      <= 8'hFF;
        end else begin
            sync1_q    <= mode_sw_i;
            sync2_q    <= sync1_q;
            cand_q     <= cand_d;
            dbCnt_q    <= dbCnt_d;
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            digit_q    <= digit_d;
            snap_q     <= snap_d;
            snapMode_q <= snapMode_d;
            memAddr_q  <= memAddr_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign mem_addr_o = memAddr_q;
    assign mode_q_o   = mode_q;
    assign an_o       = an_q;
    assign seg_o      = seg_q;

endmodule

// File: tb/tb_stat_display_ctrl.sv
// tb_stat_display_ctrl
//   Bench for stat_display_ctrl with SCAN_DIV=4, DEBOUNCE_CYC=4 (one frame
//   is 32 clocks). A reference model derived from the edge count since
//   reset predicts every output on every cycle; a vector table and a few
//   hand-written sequences cover whole frames and the multi-cycle corners.
module tb_stat_display_ctrl;

    localparam int SD = 4;
    localparam int DB = 4;
    localparam int FRAME = 8 * SD;
    localparam int NV = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dispEn = 1'b1;
    logic [2:0]  modeSw = 3'd0;
    logic [11:0] addrSw = 12'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] cycCnt = 32'd0;
    logic [31:0] brCond = 32'd0;
    logic [31:0] brTaken = 32'd0;
    logic [31:0] brUncond = 32'd0;
    logic [31:0] memRdata;
    logic [11:0] memAddr;
    logic [2:0]  modeQ;
    logic [7:0]  an;
    logic [7:0]  seg;

    int total = 0;
    int bad = 0;

    // Font written independently of the RTL, as hex of {g..a} active-low.
    logic [6:0] fontTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Data memory contents seen by the read port.
    function automatic logic [31:0] memF(input logic [11:0] a);
        return {a, 4'h5, ~a, 4'hA};
    endfunction

    assign memRdata = memF(memAddr);

    stat_display_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .disp_en_i       (dispEn),
        .mode_sw_i       (modeSw),
        .addr_sw_i       (addrSw),
        .pc_i            (pc),
        .cycle_cnt_i     (cycCnt),
        .br_cond_cnt_i   (brCond),
        .br_taken_cnt_i  (brTaken),
        .br_uncond_cnt_i (brUncond),
        .mem_rdata_i     (memRdata),
        .mem_addr_o      (memAddr),
        .mode_q_o        (modeQ),
        .an_o            (an),
        .seg_o           (seg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // n counts rising edges since reset release; rawHist[k-1] is the switch
    // value seen just before edge k.
    int          n = 0;
    logic [2:0]  rawHist[$];
    logic [2:0]  mMode = 3'd0;
    logic [31:0] mSnap = 32'd0;
    logic [2:0]  mSnapMode = 3'd0;
    logic [11:0] mAddr = 12'd0;
    logic [7:0]  expAn = 8'hFF;
    logic [7:0]  expSeg = 8'hFF;

    // Synchronized switch value as seen before edge k (two-clock delay).
    function automatic logic [2:0] sAt(input int k);
        if (k < 3) return 3'd0;
        return rawHist[k - 3];
    endfunction

    // A value is accepted once the synchronized switches have shown it on
    // DB+1 consecutive edges (the capture edge plus DB stable edges).
    function automatic logic windowStable(input int k);
        for (int j = k - DB; j < k; j++)
            if (sAt(j) != sAt(k)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] selModel(input logic [2:0] m);
        case (m)
            3'd0: return memF(mAddr);
            3'd1: return pc;
            3'd2: return cycCnt;
            3'd3: return brCond;
            3'd4: return brTaken;
            3'd5: return brUncond;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int d;
        logic [2:0] oldMode;
        logic [3:0] nib;
        if (!rst_n) begin
            n = 0;
            rawHist.delete();
            mMode = 3'd0;
            mSnap = 32'd0;
            mSnapMode = 3'd0;
            mAddr = 12'd0;
            expAn = 8'hFF;
            expSeg = 8'hFF;
        end else begin
            n++;
            rawHist.push_back(modeSw);
            oldMode = mMode;
            d = ((n - 1) / SD) % 8;
            if (!dispEn || oldMode[2:1] == 2'b11 || mSnapMode[2:1] == 2'b11) begin
                expAn = 8'hFF;
                expSeg = 8'hFF;
            end else begin
                expAn = ~(8'd1 << d);
                nib = mSnap[d*4 +: 4];
                expSeg = {!(d == 0 && oldMode != mSnapMode), fontTab[nib]};
            end
            if (n % FRAME == 0) begin
                mSnap = selModel(oldMode);
                mSnapMode = oldMode;
                mAddr = addrSw;
            end
            if (windowStable(n)) mMode = sAt(n);
        end
    end

    // Every cycle, away from the active edge, the DUT must match the model.
    always @(negedge clk) begin
        checkOutput("an", {24'd0, an}, {24'd0, expAn});
        checkOutput("seg", {24'd0, seg}, {24'd0, expSeg});
        checkOutput("mode_q", {29'd0, modeQ}, {29'd0, mMode});
        checkOutput("mem_addr", {20'd0, memAddr}, {20'd0, mAddr});
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  mode;
        logic        en;
        logic [11:0] addr;
        logic [31:0] word;
        logic        expBlank;
        logic [31:0] expWord;
    } vec_t;

    vec_t vecs[NV];
    logic [7:0] frameSeg[8];
    logic       frameSeen[8];

    task automatic applyStimulus(input vec_t v);
        modeSw   = v.mode;
        dispEn   = v.en;
        addrSw   = v.addr;
        pc       = $urandom;
        cycCnt   = $urandom;
        brCond   = $urandom;
        brTaken  = $urandom;
        brUncond = $urandom;
        case (v.mode)
            3'd1: pc = v.word;
            3'd2: cycCnt = v.word;
            3'd3: brCond = v.word;
            3'd4: brTaken = v.word;
            3'd5: brUncond = v.word;
            default: ;
        endcase
    endtask

    initial begin
        logic [7:0] anExp;
        logic       lit;
        logic       found;

        vecs[0] = '{3'd1, 1'b1, 12'h000, 32'h0040_1A3C, 1'b0, 32'h0040_1A3C};
        vecs[1] = '{3'd2, 1'b1, 12'h000, 32'h89AB_CDEF, 1'b0, 32'h89AB_CDEF};
        vecs[2] = '{3'd3, 1'b1, 12'h000, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF};
        vecs[3] = '{3'd0, 1'b1, 12'h010, 32'h0000_0000, 1'b0, 32'h0105_FEFA};
        vecs[4] = '{3'd5, 1'b1, 12'h000, 32'hFEDC_BA98, 1'b0, 32'hFEDC_BA98};
        vecs[5] = '{3'd6, 1'b1, 12'h000, 32'h1111_1111, 1'b1, 32'h0};
        vecs[6] = '{3'd4, 1'b1, 12'h000, 32'h2468_ACE0, 1'b0, 32'h2468_ACE0};
        vecs[7] = '{3'd1, 1'b0, 12'h000, 32'h5555_AAAA, 1'b1, 32'h0};
        vecs[8] = '{3'd7, 1'b1, 12'h000, 32'h7777_7777, 1'b1, 32'h0};

        // Reset release and the anode walk FE, FD, ..., 7F, FE.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if ((k - 1) % SD == 0) begin
                anExp = ~(8'd1 << (((k - 1) / SD) % 8));
                checkOutput("anWalk", {24'd0, an}, {24'd0, anExp});
            end
        end

        // Asynchronous reset in the middle of a digit.
        modeSw = 3'd1;
        pc = 32'hDEAD_BEEF;
        repeat (45) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstAn", {24'd0, an}, 32'hFF);
        checkOutput("rstSeg", {24'd0, seg}, 32'hFF);
        checkOutput("rstMode", {29'd0, modeQ}, 32'd0);
        checkOutput("rstAddr", {20'd0, memAddr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstFirstAn", {24'd0, an}, 32'hFE);

        // Whole frames from the vector table.
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            repeat (72) @(negedge clk);
            lit = 1'b0;
            for (int j = 0; j < 8; j++) begin
                frameSeg[j] = 8'h00;
                frameSeen[j] = 1'b0;
            end
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                if (an != 8'hFF || seg != 8'hFF) lit = 1'b1;
                for (int j = 0; j < 8; j++) begin
                    anExp = ~(8'd1 << j);
                    if (an == anExp) begin
                        frameSeg[j] = seg;
                        frameSeen[j] = 1'b1;
                    end
                end
            end
            if (vecs[i].expBlank) begin
                checkOutput("frameBlank", {31'd0, lit}, 32'd0);
            end else begin
                for (int j = 0; j < 8; j++)
                    checkOutput("frameDigit", {24'd0, frameSeg[j]},
                                {24'd0, 1'b1, fontTab[vecs[i].expWord[j*4 +: 4]]});
            end
        end

        // Bounce: a 2-cycle pulse is ignored, a held value lands on the 7th edge.
        modeSw = 3'd0;
        dispEn = 1'b1;
        repeat (20) @(negedge clk);
        modeSw = 3'd2;
        repeat (2) @(negedge clk);
        modeSw = 3'd0;
        repeat (12) @(negedge clk);
        checkOutput("bounceIgnored", {29'd0, modeQ}, 32'd0);
        cycCnt = 32'hC0FF_EE01;
        modeSw = 3'd2;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) checkOutput("debounceEarly", {29'd0, modeQ}, 32'd0);
            if (k == 7) checkOutput("debounceLand", {29'd0, modeQ}, 32'd2);
        end
        repeat (40) @(negedge clk);

        // Memory address loads only on a frame boundary; disp_en=0 blanks
        // while the address keeps following the switches.
        modeSw = 3'd0;
        addrSw = 12'h010;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (n % FRAME == 0) found = 1'b1;
        end
        checkOutput("boundaryFound", {31'd0, found}, 32'd1);
        checkOutput("memAddrLoad", {20'd0, memAddr}, 32'h010);
        dispEn = 1'b0;
        addrSw = 12'h3A5;
        repeat (40) @(negedge clk);
        checkOutput("disBlankAn", {24'd0, an}, 32'hFF);
        checkOutput("disBlankSeg", {24'd0, seg}, 32'hFF);
        checkOutput("disAddr", {20'd0, memAddr}, 32'h3A5);
        dispEn = 1'b1;

        // Coherence: pc churns every cycle, the model holds the boundary value.
        modeSw = 3'd1;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 100; k++) begin
            pc = $urandom;
            @(negedge clk);
        end

        // Random phase checked cycle by cycle against the model.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(5) == 0) modeSw = 3'($urandom_range(7));
            dispEn   = ($urandom_range(7) != 0);
            addrSw   = 12'($urandom);
            pc       = $urandom;
            cycCnt   = $urandom;
            brCond   = $urandom;
            brTaken  = $urandom;
            brUncond = $urandom;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
